// File: rtl/m4_sync_conditioner.sv
// m4_sync_conditioner
// Front end for the TRS-80 Model 4 input monitor, clocked by dotclk.
// Synchronizes and glitch-filters the raw hsync/vsync pins, delay-matches
// video, produces one-cycle line/frame strobes, measures dots per line and
// lines per frame, and decides 64/80-column mode with multi-frame confirmation.
//
// Ports:
//   dotclk          in   M4 dot clock, all logic on the rising edge
//   rst_n           in   synchronous active-low reset
//   hsync_in        in   raw hsync (async, active low)
//   vsync_in        in   raw vsync (async, active low)
//   video_in        in   raw video (async)
//   hsync_clean     out  filtered hsync
//   vsync_clean     out  filtered vsync
//   video_q         out  synchronized video, same latency as the sync outputs
//   line_strobe     out  1-cycle pulse after hsync_clean falls
//   frame_strobe    out  1-cycle pulse after vsync_clean falls
//   line_len[9:0]   out  cycles between the last two line strobes (sat. 1023)
//   line_len_valid  out  set once two line strobes have been seen
//   lines_per_frame out  accumulated lines of the last closed frame (sat. 511)
//   mode_80col      out  0 = 64-column, 1 = 80-column
//   mode_change     out  1-cycle pulse when mode_80col flips
module m4_sync_conditioner #(
  parameter int SYNC_FILT    = 3,
  parameter int MIN_LINE     = 320,
  parameter int MODE_THRESH  = 720,
  parameter int MODE_CONFIRM = 2
) (
  input  logic       dotclk,
  input  logic       rst_n,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       video_in,
  output logic       hsync_clean,
  output logic       vsync_clean,
  output logic       video_q,
  output logic       line_strobe,
  output logic       frame_strobe,
  output logic [9:0] line_len,
  output logic       line_len_valid,
  output logic [8:0] lines_per_frame,
  output logic       mode_80col,
  output logic       mode_change
);

  localparam logic [3:0] FILT_LAST = 4'(SYNC_FILT - 1);
  localparam logic [2:0] CONFIRM   = 3'(MODE_CONFIRM);
  localparam logic [9:0] MIN_LEN   = 10'(MIN_LINE);
  localparam logic [9:0] THRESH    = 10'(MODE_THRESH);
  localparam logic [0:0] MODE64    = 1'b0;
  localparam logic [0:0] MODE80    = 1'b1;

  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

  function automatic logic [8:0] sat_inc9(input logic [8:0] v);
    return (v == 9'h1FF) ? v : v + 9'd1;
  endfunction

  logic                 r_hs_s1, r_hs_s2, r_vs_s1, r_vs_s2, r_vid_s1, r_vid_s2;
  logic [3:0]           r_hs_cnt, r_vs_cnt;
  logic                 r_hs_clean, r_vs_clean, r_hs_d, r_vs_d;
  logic [SYNC_FILT-1:0] r_vid_sh;
  logic                 r_line_strobe, r_frame_strobe;
  logic [9:0]           r_dot_cnt, r_line_len, r_frame_max;
  logic                 r_seen, r_len_valid;
  logic [8:0]           r_line_cnt, r_lines_per_frame;
  logic [0:0]           r_state;
  logic [2:0]           r_vote;
  logic                 r_mode_80col, r_mode_change;

  logic [9:0]           w_len_nx, w_fmax_nx;
  logic [8:0]           w_lcnt_nx;
  logic                 w_acc;
  logic [0:0]           w_cand;

  // Two-flop synchronizers for all three raw pins.
  always_ff @(posedge dotclk) begin
    if (!rst_n) begin
      {r_hs_s1, r_hs_s2, r_vs_s1, r_vs_s2, r_vid_s1, r_vid_s2} <= 6'b111111;
    end else begin
      r_hs_s1  <= hsync_in;  r_hs_s2  <= r_hs_s1;
      r_vs_s1  <= vsync_in;  r_vs_s2  <= r_vs_s1;
      r_vid_s1 <= video_in;  r_vid_s2 <= r_vid_s1;
    end
  end

  // hsync persistence filter: clean level follows after SYNC_FILT differing cycles.
  always_ff @(posedge dotclk) begin
    if (!rst_n) begin
      r_hs_cnt <= 4'd0; r_hs_clean <= 1'b1;
    end else if (r_hs_s2 == r_hs_clean) begin
      r_hs_cnt <= 4'd0;
    end else if (r_hs_cnt == FILT_LAST) begin
      r_hs_cnt <= 4'd0; r_hs_clean <= r_hs_s2;
    end else begin
      r_hs_cnt <= r_hs_cnt + 4'd1;
    end
  end

  // vsync persistence filter, identical to the hsync one.
  always_ff @(posedge dotclk) begin
    if (!rst_n) begin
      r_vs_cnt <= 4'd0; r_vs_clean <= 1'b1;
    end else if (r_vs_s2 == r_vs_clean) begin
      r_vs_cnt <= 4'd0;
    end else if (r_vs_cnt == FILT_LAST) begin
      r_vs_cnt <= 4'd0; r_vs_clean <= r_vs_s2;
    end else begin
      r_vs_cnt <= r_vs_cnt + 4'd1;
    end
  end

  // Video delay line, SYNC_FILT deep so it lines up with the filtered syncs.
  always_ff @(posedge dotclk) begin
    if (!rst_n) begin
      r_vid_sh <= {SYNC_FILT{1'b0}};
    end else begin
      r_vid_sh[0] <= r_vid_s2;
      for (int i = 1; i < SYNC_FILT; i++) r_vid_sh[i] <= r_vid_sh[i-1];
    end
  end

  // Falling-edge detectors on the clean syncs.
  always_ff @(posedge dotclk) begin
    if (!rst_n) begin
      r_hs_d <= 1'b1; r_vs_d <= 1'b1;
      r_line_strobe <= 1'b0; r_frame_strobe <= 1'b0;
    end else begin
      r_hs_d <= r_hs_clean; r_vs_d <= r_vs_clean;
      r_line_strobe  <= r_hs_d & ~r_hs_clean;
      r_frame_strobe <= r_vs_d & ~r_vs_clean;
    end
  end

  // A strobe closes a measurable line only when an earlier strobe opened it.
  // Lines count toward the frame while vsync is high, or when their strobe
  // lands on the frame strobe itself (that line belongs to the closing frame).
  assign w_len_nx  = sat_inc10(r_dot_cnt);
  assign w_acc     = r_line_strobe & r_seen & (r_vs_clean | r_frame_strobe);
  assign w_fmax_nx = (w_acc && (w_len_nx > r_frame_max)) ? w_len_nx : r_frame_max;
  assign w_lcnt_nx = w_acc ? sat_inc9(r_line_cnt) : r_line_cnt;
  assign w_cand    = (w_fmax_nx > THRESH) ? MODE80 : MODE64;

  // Dot counter and line length measurement.
  always_ff @(posedge dotclk) begin
    if (!rst_n) begin
      r_dot_cnt <= 10'd0; r_line_len <= 10'd0; r_seen <= 1'b0; r_len_valid <= 1'b0;
    end else if (r_line_strobe) begin
      r_dot_cnt <= 10'd0;
      r_seen    <= 1'b1;
      if (r_seen) begin
        r_line_len  <= w_len_nx;
        r_len_valid <= 1'b1;
      end else begin
        r_line_len  <= r_line_len;
      end
    end else begin
      r_dot_cnt <= w_len_nx;
    end
  end

  // Per-frame max line length and line count; snapshot on frame close.
  always_ff @(posedge dotclk) begin
    if (!rst_n) begin
      r_frame_max <= 10'd0; r_line_cnt <= 9'd0; r_lines_per_frame <= 9'd0;
    end else if (r_frame_strobe) begin
      r_lines_per_frame <= w_lcnt_nx;
      r_frame_max <= 10'd0; r_line_cnt <= 9'd0;
    end else begin
      r_frame_max <= w_fmax_nx; r_line_cnt <= w_lcnt_nx;
    end
  end

  // Mode FSM with vote counter; outputs trail the state by one register.
  always_ff @(posedge dotclk) begin
    if (!rst_n) begin
      r_state <= MODE64; r_vote <= 3'd0; r_mode_80col <= 1'b0; r_mode_change <= 1'b0;
    end else begin
      r_mode_80col  <= (r_state == MODE80);
      r_mode_change <= (r_state == MODE80) != r_mode_80col;
      // Short-line frames (e.g. garbage during a mode switch) cast no vote.
      if (r_frame_strobe && (w_fmax_nx > MIN_LEN)) begin
        case (r_state)
          MODE64, MODE80: begin
            if (w_cand == r_state) begin
              r_vote <= 3'd0;
            end else if ((r_vote + 3'd1) == CONFIRM) begin
              r_state <= w_cand; r_vote <= 3'd0;
            end else begin
              r_vote <= r_vote + 3'd1;
            end
          end
          default: begin
            r_state <= MODE64; r_vote <= 3'd0;
          end
        endcase
      end
    end
  end

  assign hsync_clean     = r_hs_clean;
  assign vsync_clean     = r_vs_clean;
  assign video_q         = r_vid_sh[SYNC_FILT-1];
  assign line_strobe     = r_line_strobe;
  assign frame_strobe    = r_frame_strobe;
  assign line_len        = r_line_len;
  assign line_len_valid  = r_len_valid;
  assign lines_per_frame = r_lines_per_frame;
  assign mode_80col      = r_mode_80col;
  assign mode_change     = r_mode_change;

endmodule

// File: tb/tb_m4_sync_conditioner.sv
// Directed testbench for m4_sync_conditioner (default parameters).
module tb_m4_sync_conditioner;

  logic       dotclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       hsync_in = 1'b1, vsync_in = 1'b1, video_in = 1'b0;
  logic       hsync_clean, vsync_clean, video_q, line_strobe, frame_strobe;
  logic [9:0] line_len;
  logic       line_len_valid;
  logic [8:0] lines_per_frame;
  logic       mode_80col, mode_change;

  int n_checks = 0;
  int n_pass   = 0;
  int n_mc     = 0;
  int mc_base;
  int hs_lo;
  int n_ls;

  m4_sync_conditioner dut (
    .dotclk(dotclk), .rst_n(rst_n),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .video_in(video_in),
    .hsync_clean(hsync_clean), .vsync_clean(vsync_clean), .video_q(video_q),
    .line_strobe(line_strobe), .frame_strobe(frame_strobe),
    .line_len(line_len), .line_len_valid(line_len_valid),
    .lines_per_frame(lines_per_frame),
    .mode_80col(mode_80col), .mode_change(mode_change)
  );

  always #5 dotclk = ~dotclk;

  // Count every cycle that mode_change is high.
  always @(posedge dotclk) begin
    if (mode_change) n_mc <= n_mc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge dotclk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  // One line: hsync low for 32 cycles, period = dots.
  task automatic hline(input int dots);
    hsync_in = 1'b0; ticks(32);
    hsync_in = 1'b1; ticks(dots - 32);
  endtask

  // Leading line releases vsync mid-line, n active lines, then a closing line
  // that is still counted and drops vsync mid-line: n+1 lines of length dots.
  task automatic frame(input int n, input int dots);
    hsync_in = 1'b0; ticks(32); hsync_in = 1'b1; ticks(68);
    vsync_in = 1'b1; ticks(dots - 100);
    for (int i = 0; i < n; i++) hline(dots);
    hsync_in = 1'b0; ticks(32); hsync_in = 1'b1; ticks(68);
    vsync_in = 1'b0; ticks(dots - 100);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1; video_in = 1'b0;
    ticks(4);
    rst_n = 1'b1; ticks(10);
  endtask

  initial begin
    // Reset with sync pins toggling.
    for (int i = 0; i < 4; i++) begin
      hsync_in = i[0]; vsync_in = ~i[0];
      tick();
    end
    check("rst_hs_clean", 32'(hsync_clean), 32'd1);
    check("rst_vs_clean", 32'(vsync_clean), 32'd1);
    check("rst_video_q", 32'(video_q), 32'd0);
    check("rst_line_strobe", 32'(line_strobe), 32'd0);
    check("rst_frame_strobe", 32'(frame_strobe), 32'd0);
    check("rst_line_len", 32'(line_len), 32'd0);
    check("rst_len_valid", 32'(line_len_valid), 32'd0);
    check("rst_lpf", 32'(lines_per_frame), 32'd0);
    check("rst_mode", 32'(mode_80col), 32'd0);
    check("rst_mode_change", 32'(mode_change), 32'd0);
    rst_n = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1; video_in = 1'b0;
    ticks(10);

    // 2-cycle glitch is suppressed.
    hsync_in = 1'b0; ticks(2); hsync_in = 1'b1;
    hs_lo = 0; n_ls = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (!hsync_clean) hs_lo++;
      if (line_strobe) n_ls++;
    end
    check("glitch_hs_low_cycles", 32'(hs_lo), 32'd0);
    check("glitch_strobes", 32'(n_ls), 32'd0);

    // Stable fall: clean on 5th edge, strobe on 6th, video aligned.
    hsync_in = 1'b0; video_in = 1'b1;
    ticks(4);
    check("lat4_hs_clean", 32'(hsync_clean), 32'd1);
    check("lat4_video_q", 32'(video_q), 32'd0);
    tick();
    check("lat5_hs_clean", 32'(hsync_clean), 32'd0);
    check("lat5_video_q", 32'(video_q), 32'd1);
    check("lat5_strobe", 32'(line_strobe), 32'd0);
    tick();
    check("lat6_strobe", 32'(line_strobe), 32'd1);
    tick();
    check("lat7_strobe", 32'(line_strobe), 32'd0);

    // Line length measurement.
    hsync_in = 1'b1; video_in = 1'b0; ticks(20);
    check("one_strobe_valid", 32'(line_len_valid), 32'd0);
    check("one_strobe_len", 32'(line_len), 32'd0);
    hline(640);
    check("two_strobe_valid", 32'(line_len_valid), 32'd1);
    hline(640); hline(640);
    check("len_640", 32'(line_len), 32'd640);
    hline(2000); hline(64);
    check("len_sat", 32'(line_len), 32'd1023);
    check("len_valid_held", 32'(line_len_valid), 32'd1);

    // Mode switch to 80 columns needs two agreeing frames.
    do_reset();
    mc_base = n_mc;
    frame(3, 800);
    check("f1_mode", 32'(mode_80col), 32'd0);
    check("f1_changes", 32'(n_mc - mc_base), 32'd0);
    frame(3, 800);
    check("f2_mode", 32'(mode_80col), 32'd1);
    check("f2_changes", 32'(n_mc - mc_base), 32'd1);
    check("f2_lpf", 32'(lines_per_frame), 32'd4);
    // A disagreeing frame followed by an agreeing one clears the vote.
    frame(3, 640); frame(3, 800); frame(3, 640);
    check("clr_mode", 32'(mode_80col), 32'd1);
    check("clr_changes", 32'(n_mc - mc_base), 32'd1);
    // Short-line frame casts no vote and keeps the pending count.
    frame(9, 200);
    check("short_mode", 32'(mode_80col), 32'd1);
    check("short_lpf", 32'(lines_per_frame), 32'd10);
    frame(3, 640);
    check("after_short_mode", 32'(mode_80col), 32'd0);
    check("after_short_changes", 32'(n_mc - mc_base), 32'd2);

    // 64-column glitch frame, then coincident line/frame strobe.
    do_reset();
    mc_base = n_mc;
    frame(3, 640);
    frame(9, 200);
    check("g64_mode", 32'(mode_80col), 32'd0);
    check("g64_lpf", 32'(lines_per_frame), 32'd10);
    frame(3, 800);
    check("pre_sim_mode", 32'(mode_80col), 32'd0);
    hsync_in = 1'b0; ticks(32); hsync_in = 1'b1; ticks(68);
    vsync_in = 1'b1; ticks(540);
    for (int i = 0; i < 3; i++) hline(640);
    ticks(160);
    hsync_in = 1'b0; vsync_in = 1'b0; ticks(32);
    hsync_in = 1'b1; ticks(768);
    check("sim_lpf", 32'(lines_per_frame), 32'd4);
    check("sim_mode", 32'(mode_80col), 32'd1);
    check("sim_changes", 32'(n_mc - mc_base), 32'd1);
    check("sim_line_len", 32'(line_len), 32'd800);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/m4_sync_conditioner.md
Name: m4_sync_conditioner

Overview:
Front-end stage that sits directly upstream of the M4 input monitor, in the dotclk domain. It synchronizes and glitch-filters the raw TRS-80 Model 4 hsync, vsync and video pins, and emits one-cycle line and frame strobes. It measures dots per line and lines per frame, and decides 64- versus 80-column mode with multi-frame confirmation. The monitor consumes clean, aligned signals plus a stable mode flag instead of raw pins.

Parameters:
SYNC_FILT, 3, consecutive cycles a synchronized sync level must persist before the clean output follows (1..15)
MIN_LINE, 320, frame max line length <= this is ignored for mode decisions
MODE_THRESH, 720, frame max line length > this votes 80-column, otherwise 64-column
MODE_CONFIRM, 2, consecutive disagreeing frames required to flip mode (1..7)

Ports:
dotclk  in  1  M4 dot clock; all logic on rising edge
rst_n  in  1  synchronous active-low reset
hsync_in  in  1  raw hsync, asynchronous, active low
vsync_in  in  1  raw vsync, asynchronous, active low
video_in  in  1  raw video, asynchronous
hsync_clean  out  1  filtered hsync
vsync_clean  out  1  filtered vsync
video_q  out  1  synchronized video, delay-matched to the sync outputs
line_strobe  out  1  1-cycle pulse on the falling edge of hsync_clean
frame_strobe  out  1  1-cycle pulse on the falling edge of vsync_clean
line_len  out  10  dotclk cycles between the last two line_strobes, saturating at 1023
line_len_valid  out  1  high once two line_strobes have been seen since reset
lines_per_frame  out  9  active lines in the last complete frame, saturating at 511
mode_80col  out  1  0 = 64-column, 1 = 80-column
mode_change  out  1  1-cycle pulse when mode_80col flips

Behaviour:
- Reset (rst_n sampled low on a rising edge):
  - hsync_clean = 1, vsync_clean = 1; synchronizer flops = 1.
  - All other outputs = 0; all counters = 0; vote counter = 0.
  - Reset mid-line discards the partial line; line_len_valid must re-qualify.
- Synchronizer: two flops per input.
- Filter, per sync: a counter runs while the synchronized level differs from the clean output and clears when they match.
  - The clean output takes the new level on the edge where the counter would reach SYNC_FILT.
  - Total latency from a stable input change is 2+SYNC_FILT edges (5 at default).
  - Pulses shorter than SYNC_FILT cycles are suppressed entirely.
- video_q: synchronized video passed through a SYNC_FILT-deep shift register, so its latency is also 2+SYNC_FILT; no filtering.
- Strobes: registered edge detect on the clean signals; each asserts for exactly one cycle, on the cycle after the clean signal falls.
- Line measurement:
  - dot_cnt increments every cycle, saturating at 1023.
  - On line_strobe: line_len <= sat(dot_cnt+1), dot_cnt <= 0.
  - Strobes at cycles t and t+N give line_len = N.
  - The first strobe after reset only clears dot_cnt; line_len_valid sets on the second strobe and stays high until reset.
- Frame accumulation:
  - While vsync_clean = 1, each line_strobe with line_len_valid updates frame_max = max(frame_max, new line_len) and increments line_cnt (saturating at 511).
  - Lines during vsync_clean = 0 are measured but not accumulated.
  - line_strobe coinciding with frame_strobe: that line is included in the closing frame.
- Frame close (on frame_strobe):
  - lines_per_frame <= line_cnt (including any coincident line).
  - Mode vote is evaluated.
  - frame_max and line_cnt clear to 0.
- Mode FSM, states MODE64 and MODE80, plus a 3-bit vote counter:
  - frame_max <= MIN_LINE: no vote; counter unchanged.
  - candidate = (frame_max > MODE_THRESH).
  - candidate equals current mode: counter <= 0.
  - Otherwise counter increments. On reaching MODE_CONFIRM:
    - change state; mode_80col flips on the next edge;
    - mode_change pulses that same cycle;
    - counter <= 0.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- Reset: hold rst_n = 0 for 4 cycles with sync inputs toggling -> hsync_clean = vsync_clean = 1; all other outputs 0.
- Filter: 2-cycle low glitch on hsync_in -> hsync_clean stays 1, no line_strobe. Then hold hsync_in low -> hsync_clean falls on the 5th edge, line_strobe on the 6th, video_q edge aligned with hsync_clean.
- Line length: hsync falls every 640 cycles -> line_len = 640 and line_len_valid = 1 after the second strobe. A 2000-cycle gap -> line_len = 1023.
- Mode switch: frames of 240 lines at 800 dots from reset -> frame 1 has no mode_change; frame 2 close gives mode_80col = 1 with one mode_change pulse. A following 640-dot frame then an 800-dot frame -> counter clears, no flip.
- Glitch frame: frame with all lines at 200 dots between 640-dot frames in 64-column mode -> no vote, mode_80col stays 0; lines_per_frame reports that frame's count.
- Simultaneous: line_strobe and frame_strobe in the same cycle with line_len = 800 while frame_max = 640 -> that frame votes 80-column; lines_per_frame includes the line.
